// File: rtl/mole_controller.sv
// Whack-a-mole game control: picks the lit hole from the LFSR value, times the mole, scores hits and misses.
// All outputs are registered and update one cycle after the deciding tick, hit or start.
module mole_controller #(
  parameter int UP_TICKS  = 800,
  parameter int GAP_TICKS = 300,
  parameter int MAX_MISS  = 5,
  parameter int TIMER_W   = 12
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        tick,
  input  logic        start,
  input  logic [5:0]  rand_num,
  input  logic [15:0] hit_btn,
  output logic [15:0] mole_led,
  output logic [7:0]  score,
  output logic [3:0]  misses,
  output logic        game_over
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] GAP  = 2'd1;
  localparam logic [1:0] UP   = 2'd2;
  localparam logic [1:0] OVER = 2'd3;

  localparam logic [TIMER_W-1:0] GAP_LAST = TIMER_W'(GAP_TICKS - 1);
  localparam logic [TIMER_W-1:0] UP_LAST  = TIMER_W'(UP_TICKS - 1);
  localparam logic [3:0]         MISS_END = 4'(MAX_MISS);

  logic [1:0]         state;
  logic [TIMER_W-1:0] timer;
  // Index of the most recent mole; while UP it is also the lit hole.
  logic [3:0]         prev_idx;
  logic [3:0]         raw_idx;
  logic [3:0]         next_idx;
  logic               unused_rand;

  assign raw_idx     = rand_num[3:0];
  assign next_idx    = (raw_idx == prev_idx) ? raw_idx + 4'd1 : raw_idx;
  assign unused_rand = ^rand_num[5:4];

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      timer     <= '0;
      prev_idx  <= 4'hF;
      mole_led  <= '0;
      score     <= '0;
      misses    <= '0;
      game_over <= 1'b0;
    end else if (start) begin
      // A restart from any state beats a hit or timeout in the same cycle.
      state     <= GAP;
      timer     <= '0;
      mole_led  <= '0;
      score     <= '0;
      misses    <= '0;
      game_over <= 1'b0;
    end else begin
      case (state)
        GAP: begin
          if (tick) begin
            if (timer == GAP_LAST) begin
              prev_idx <= next_idx;
              mole_led <= 16'd1 << next_idx;
              timer    <= '0;
              state    <= UP;
            end else begin
              timer <= timer + 1'b1;
            end
          end
        end
        UP: begin
          if (hit_btn[prev_idx]) begin
            if (score != 8'hFF) score <= score + 8'd1;
            mole_led <= '0;
            timer    <= '0;
            state    <= GAP;
          end else if (tick) begin
            if (timer == UP_LAST) begin
              misses   <= misses + 4'd1;
              mole_led <= '0;
              timer    <= '0;
              if (misses + 4'd1 == MISS_END) begin
                state     <= OVER;
                game_over <= 1'b1;
              end else begin
                state <= GAP;
              end
            end else begin
              timer <= timer + 1'b1;
            end
          end
        end
        default: begin
          mole_led <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mole_controller.sv
// Directed bench for mole_controller with UP_TICKS=4, GAP_TICKS=2, MAX_MISS=3.
module tb_mole_controller;

  logic        clk = 1'b0;
  logic        rst;
  logic        tick;
  logic        start;
  logic [5:0]  rand_num;
  logic [15:0] hit_btn;
  logic [15:0] mole_led;
  logic [7:0]  score;
  logic [3:0]  misses;
  logic        game_over;

  int n_checks = 0;
  int n_errors = 0;

  mole_controller #(
    .UP_TICKS (4),
    .GAP_TICKS(2),
    .MAX_MISS (3),
    .TIMER_W  (4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .tick     (tick),
    .start    (start),
    .rand_num (rand_num),
    .hit_btn  (hit_btn),
    .mole_led (mole_led),
    .score    (score),
    .misses   (misses),
    .game_over(game_over)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Inputs are applied 1 time unit after a rising edge, sampled at the next edge,
  // and outputs are observed 1 time unit after that edge.
  task automatic step(input logic t, input logic s, input logic [15:0] h);
    tick    = t;
    start   = s;
    hit_btn = h;
    @(posedge clk);
    #1;
    tick    = 1'b0;
    start   = 1'b0;
    hit_btn = '0;
  endtask

  task automatic gap_to_up();
    step(1'b1, 1'b0, '0);
    step(1'b1, 1'b0, '0);
  endtask

  initial begin
    rst = 1'b1; tick = 1'b1; start = 1'b1; rand_num = 6'h25; hit_btn = 16'hFFFF;
    @(posedge clk); #1;
    @(posedge clk); #1;
    tick = 1'b1; start = 1'b1; hit_btn = 16'hFFFF;
    check("rst_led", mole_led, 16'h0);
    check("rst_score", score, 8'd0);
    check("rst_misses", misses, 4'd0);
    check("rst_go", game_over, 1'b0);
    rst = 1'b0;

    // IDLE ignores ticks and buttons
    step(1'b1, 1'b0, 16'hFFFF);
    step(1'b1, 1'b0, 16'hFFFF);
    step(1'b1, 1'b0, 16'hFFFF);
    check("idle_led", mole_led, 16'h0);
    check("idle_score", score, 8'd0);

    // Basic hit: idx 5
    step(1'b0, 1'b1, '0);
    step(1'b1, 1'b0, '0);
    check("gap_dark", mole_led, 16'h0);
    step(1'b1, 1'b0, '0);
    check("basic_led", mole_led, 16'h0020);
    step(1'b0, 1'b0, 16'h0020);
    check("basic_score", score, 8'd1);
    check("basic_clear", mole_led, 16'h0);
    gap_to_up();
    check("back_in_gap", mole_led, 16'h0040);

    // Repeat avoidance from a fresh reset
    rst = 1'b1;
    step(1'b0, 1'b0, '0);
    rst = 1'b0;
    check("rst2_led", mole_led, 16'h0);
    check("rst2_score", score, 8'd0);
    rand_num = 6'h05;
    step(1'b0, 1'b1, '0);
    gap_to_up();
    check("rep_first", mole_led, 16'h0020);
    step(1'b0, 1'b0, 16'h0020);
    gap_to_up();
    check("rep_second", mole_led, 16'h0040);
    step(1'b0, 1'b0, 16'h0040);
    check("rep_score", score, 8'd2);

    // Wrong button, then timeout: idx 3
    rand_num = 6'h03;
    gap_to_up();
    check("wrong_led", mole_led, 16'h0008);
    step(1'b1, 1'b0, 16'h0001);
    check("wrong_led_held", mole_led, 16'h0008);
    check("wrong_score", score, 8'd2);
    check("wrong_misses", misses, 4'd0);
    step(1'b1, 1'b0, '0);
    step(1'b1, 1'b0, '0);
    check("pre_timeout", mole_led, 16'h0008);
    step(1'b1, 1'b0, '0);
    check("timeout_misses", misses, 4'd1);
    check("timeout_led", mole_led, 16'h0);
    check("timeout_go", game_over, 1'b0);

    // Hit and timeout together: prev 3 -> idx 4
    gap_to_up();
    check("sim_led", mole_led, 16'h0010);
    step(1'b1, 1'b0, '0);
    step(1'b1, 1'b0, '0);
    step(1'b1, 1'b0, '0);
    step(1'b1, 1'b0, 16'h0010);
    check("sim_score", score, 8'd3);
    check("sim_misses", misses, 4'd1);
    check("sim_led_clr", mole_led, 16'h0);

    // Two more timeouts reach MAX_MISS
    for (int m = 0; m < 2; m++) begin
      gap_to_up();
      for (int t = 0; t < 4; t++) step(1'b1, 1'b0, '0);
      if (m == 0) begin
        check("miss2", misses, 4'd2);
        check("miss2_go", game_over, 1'b0);
      end
    end
    check("over_go", game_over, 1'b1);
    check("over_misses", misses, 4'd3);
    check("over_score", score, 8'd3);
    for (int t = 0; t < 5; t++) step(1'b1, 1'b0, 16'hFFFF);
    check("over_hold_score", score, 8'd3);
    check("over_hold_misses", misses, 4'd3);
    check("over_hold_led", mole_led, 16'h0);
    check("over_hold_go", game_over, 1'b1);

    // Restart from OVER: prev 4 -> idx 3
    step(1'b0, 1'b1, '0);
    check("restart_score", score, 8'd0);
    check("restart_misses", misses, 4'd0);
    check("restart_go", game_over, 1'b0);
    gap_to_up();
    check("restart_gap", mole_led, 16'h0008);

    // Score saturation: mole alternates between holes 3 and 4
    step(1'b0, 1'b0, 16'hFFFF);
    for (int k = 1; k < 260; k++) begin
      gap_to_up();
      step(1'b0, 1'b0, 16'h0018);
    end
    check("sat_score", score, 8'd255);
    check("sat_misses", misses, 4'd0);

    // start in UP wins over a hit in the same cycle
    gap_to_up();
    step(1'b0, 1'b1, 16'hFFFF);
    check("start_up_score", score, 8'd0);
    check("start_up_led", mole_led, 16'h0);
    step(1'b1, 1'b0, '0);
    check("start_up_gap", mole_led, 16'h0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mole_controller.md
Name: mole_controller

Overview:
- Game-control stage directly downstream of the 6-bit LFSR random number generator in the whack-a-mole design.
- Takes the free-running random value and picks which of 16 holes lights up (the "mole").
- Times how long the mole stays up, checks the player's button hits against the lit hole, and keeps score and miss count.
- Drives the LED array and feeds score/miss/game_over to the display logic.

Parameters:
- UP_TICKS, 800, number of tick pulses the mole stays lit before counting as a miss (min 1).
- GAP_TICKS, 300, number of tick pulses all holes stay dark between moles (min 1).
- MAX_MISS, 5, misses that end the game (1..15).
- TIMER_W, 12, timer counter width; must hold max(UP_TICKS, GAP_TICKS).

Ports:
- clk, input, 1, system clock.
- rst, input, 1, synchronous active-high reset.
- tick, input, 1, single-cycle timebase enable (e.g. 1 ms); timers advance only on tick.
- start, input, 1, single-cycle pulse: begin or restart a game.
- rand_num, input, 6, LFSR output; bits [3:0] select the hole.
- hit_btn, input, 16, debounced single-cycle button pulses, one bit per hole.
- mole_led, output, 16, one-hot lit hole; all zero when no mole is up.
- score, output, 8, hits this game, saturating at 255.
- misses, output, 4, timeouts this game.
- game_over, output, 1, high while in OVER.

Behaviour:
- Reset is synchronous, active-high and wins over all other inputs.
  - Reset values: state = IDLE, mole_led = 0, score = 0, misses = 0, game_over = 0, timer = 0, prev_idx = 4'hF.
- States: IDLE, GAP, UP, OVER. All outputs are registered.
- IDLE:
  - mole_led = 0; hit_btn is ignored.
  - start: clear score, misses and timer; go to GAP.
- GAP:
  - mole_led = 0.
  - timer increments on each tick.
  - When a tick arrives with timer == GAP_TICKS-1: latch hole index, clear timer, go to UP.
  - mole_led = one-hot(idx) in the same register update, i.e. visible the cycle after that tick.
  - Hole index: idx = rand_num[3:0]. If idx == prev_idx, use idx+1 (mod 16), so the same hole never lights twice in a row. prev_idx is updated with the final idx.
- UP:
  - timer increments on each tick.
  - Hit: hit_btn[idx] == 1 in any cycle (other bits may also be set).
    - score += 1, saturating at 255.
    - mole_led cleared next cycle; timer cleared; go to GAP.
  - Pulses only on non-lit holes are ignored: no penalty, no state change.
  - Timeout: tick with timer == UP_TICKS-1 and no hit in that cycle.
    - misses += 1; mole_led cleared; timer cleared.
    - If misses+1 == MAX_MISS, go to OVER; otherwise go to GAP.
  - Hit and timeout in the same cycle: the hit wins (score increments, misses unchanged).
- OVER:
  - game_over = 1; mole_led = 0; score and misses hold.
  - start: clear score, misses, game_over and timer; go to GAP.
- start received in GAP or UP restarts the game: clear counters and timer, mole_led = 0, go to GAP. It takes priority over a hit or timeout in the same cycle.
- Ticks arriving while in IDLE or OVER have no effect.

Test Plan (bench params UP_TICKS=4, GAP_TICKS=2, MAX_MISS=3):
- Reset check:
  - Stimulus: assert rst for 2 cycles with start=1 and tick=1.
  - Required: state stays IDLE; mole_led=0, score=0, misses=0, game_over=0.
- Basic hit:
  - Stimulus: start; tick every cycle; rand_num=6'h25.
  - Required: after 2 ticks mole_led=16'h0020.
  - Stimulus: pulse hit_btn=16'h0020.
  - Required: next cycle score=1, mole_led=0, back in GAP.
- Repeat avoidance:
  - Stimulus: hold rand_num=6'h05 across two consecutive moles.
  - Required: first mole_led=16'h0020, second mole_led=16'h0040.
- Wrong button, then timeout:
  - Stimulus: during UP with idx=3, pulse hit_btn=16'h0001.
  - Required: no change from the wrong press. After the 4th tick in UP, misses=1 and mole_led=0.
- Simultaneous hit and timeout:
  - Stimulus: hit_btn[idx] pulses in the same cycle as the 4th UP tick.
  - Required: score increments, misses unchanged.
- Game over and restart:
  - Stimulus: 3 consecutive timeouts.
  - Required: game_over=1, misses=3, score held, hit_btn ignored.
  - Stimulus: pulse start.
  - Required: score=0, misses=0, game_over=0, GAP entered.
